// File: rtl/tv80_wait_ctl.sv
// Per-region memory wait-state generator for a TV80 bus: programmable wait counts
// held in I/O-mapped config registers, plus region chip-select decode.
module tv80_wait_ctl #(
  parameter int          RSEL_W    = 1,
  parameter int          WAIT_W    = 3,
  parameter int unsigned WAIT_INIT = 0,
  parameter logic [7:0]  CFG_BASE  = 8'h10,
  parameter bit          M1_EXTRA  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mreq_n,
  input  logic                  iorq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic                  m1_n,
  input  logic                  rfsh_n,
  input  logic [15:0]           A,
  input  logic [7:0]            do_i,
  output logic                  wait_n,
  output logic [2**RSEL_W-1:0]  rd_cs,
  output logic [2**RSEL_W-1:0]  wr_cs,
  output logic                  cfg_sel,
  output logic [7:0]            cfg_dout
);

  localparam int NREG = 2**RSEL_W;

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W:0]     cnt_q, cnt_d;
  logic                wait_q, wait_d;
  logic                mreq_prev_q;
  logic [WAIT_W-1:0]   count_q [NREG];

  logic [RSEL_W-1:0]   rg;
  logic [RSEL_W-1:0]   cfg_idx;
  logic                cfg_hit;
  logic                acc_start;
  logic [WAIT_W:0]     load_n;
  logic                unused_bits;

  assign rg      = A[15 -: RSEL_W];
  assign cfg_idx = A[RSEL_W-1:0];
  // CFG_BASE is NREG-aligned, so the range check reduces to matching the upper bits.
  assign cfg_hit = !iorq_n && m1_n && (A[7:RSEL_W] == CFG_BASE[7:RSEL_W]);
  assign cfg_sel = cfg_hit && !rd_n;

  // Only some address/data bits matter for a given parameter set.
  assign unused_bits = ^{A, do_i};

  always_comb begin
    rd_cs = '0;
    wr_cs = '0;
    if (!mreq_n && !rd_n && rfsh_n) rd_cs[rg] = 1'b1;
    if (!mreq_n && !wr_n && rfsh_n) wr_cs[rg] = 1'b1;
  end

  always_comb begin
    cfg_dout = 8'h00;
    if (cfg_sel) cfg_dout[WAIT_W-1:0] = count_q[cfg_idx];
  end

  assign acc_start = !mreq_n && mreq_prev_q && rfsh_n;
  assign load_n    = {1'b0, count_q[rg]} + (WAIT_W+1)'(M1_EXTRA && !m1_n);

  // NOTE: the wait counts are architecturally visible after reset, so this small
  // register array is reset explicitly rather than left as an uninitialised memory.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) count_q[r] <= WAIT_W'(WAIT_INIT);
    end else if (cfg_hit && !wr_n) begin
      count_q[cfg_idx] <= do_i[WAIT_W-1:0];
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (acc_start) begin
          if (load_n == '0) begin
            state_d = HOLD;
            wait_d  = 1'b1;
          end else begin
            state_d = COUNT;
            cnt_d   = load_n;
            wait_d  = 1'b0;
          end
        end
      end
      COUNT: begin
        if (mreq_n) begin
          state_d = IDLE;
          cnt_d   = '0;
          wait_d  = 1'b1;
        end else if (cnt_q == (WAIT_W+1)'(1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          wait_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        wait_d = 1'b1;
        if (mreq_n) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wait_d  = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= 1'b1;
      mreq_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      mreq_prev_q <= mreq_n;
    end
  end

  assign wait_n = wait_q;

endmodule
